// File: rtl/pooling_result_writer_pkg.sv
// Shared definitions for the pooling result writer.
//   DATA_WIDTH_DEF : default sample width
//   ADDR_W         : output buffer address width
//   state_e        : completion-tracking states
//   pool_smax      : signed maximum on sign-extended operands
package pooling_result_writer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_W         = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operands are passed sign-extended to 32 bits so one function serves
  // any DATA_WIDTH up to 32; callers truncate the result back.
  function automatic logic signed [31:0] pool_smax(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pooling_result_writer_marker_delay.sv
// pool_marker_delay: RD_LATENCY-deep shift register that aligns the
// read-side markers with the buffer read data.
//   clk, rstn  : clock, synchronous active-low reset
//   clr        : synchronous clear (drops all in-flight markers)
//   valid_in, first_in, last_in    : address-aligned markers
//   valid_out, first_out, last_out : data-aligned markers
module pool_marker_delay #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic valid_in,
  input  logic first_in,
  input  logic last_in,
  output logic valid_out,
  output logic first_out,
  output logic last_out
);

  logic [RD_LATENCY-1:0] v_q, v_d;
  logic [RD_LATENCY-1:0] f_q, f_d;
  logic [RD_LATENCY-1:0] l_q, l_d;

  always_comb begin
    v_d    = v_q << 1;
    f_d    = f_q << 1;
    l_d    = l_q << 1;
    v_d[0] = valid_in;
    f_d[0] = first_in;
    l_d[0] = last_in;
    if (clr) begin
      v_d = '0;
      f_d = '0;
      l_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else begin
      v_q <= v_d;
      f_q <= f_d;
      l_q <= l_d;
    end
  end

  assign valid_out = v_q[RD_LATENCY-1];
  assign first_out = f_q[RD_LATENCY-1];
  assign last_out  = l_q[RD_LATENCY-1];

endmodule

// File: rtl/pooling_result_writer.sv
// pooling_result_writer: reduces each pooling window of read data to its
// signed maximum and writes one result per window to the output buffer.
//   clk, rstn      : clock, synchronous active-low reset
//   go             : start pulse, clears counters/pipeline/accumulator
//   cena           : active-low read enable (address-aligned)
//   first_data     : first sample of window (address-aligned)
//   last_data      : last sample of window (address-aligned)
//   din            : signed read data, RD_LATENCY cycles after cena
//   wa_data        : output write address
//   wd_data        : pooled result
//   wena           : active-low write enable
//   done           : one-cycle pulse after the final write of a run
module pooling_result_writer
  import pooling_result_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned OUTPUT_BATCH = 5,
  parameter int unsigned OUT_WIDTH    = 24,
  parameter int unsigned OUT_HEIGHT   = 24,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         go,
  input  logic                         cena,
  input  logic                         first_data,
  input  logic                         last_data,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic        [ADDR_W-1:0]     wa_data,
  output logic signed [DATA_WIDTH-1:0] wd_data,
  output logic                         wena,
  output logic                         done
);

  localparam int unsigned TOTAL = OUTPUT_BATCH * OUT_WIDTH * OUT_HEIGHT;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic signed [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic mk_valid, mk_first, mk_last;

  pool_marker_delay #(
    .RD_LATENCY(RD_LATENCY)
  ) u_marker_delay (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (go),
    .valid_in (~cena),
    .first_in (first_data),
    .last_in  (last_data),
    .valid_out(mk_valid),
    .first_out(mk_first),
    .last_out (mk_last)
  );

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]        cnt_q, cnt_d;
  logic        [ADDR_W-1:0]       wa_q, wa_d;
  logic signed [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic                           wena_q, wena_d;
  logic                           done_q, done_d;
  logic signed [DATA_WIDTH-1:0]   pooled;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    wena_d  = 1'b1;
    // DONE is entered on the edge that raises the final write strobe, so
    // done trails wena by one cycle.
    done_d  = (state_q == ST_DONE);
    pooled  = mk_first ? din : DATA_WIDTH'(pool_smax(32'(acc_q), 32'(din)));

    if (go) begin
      // go wins over a coincident last marker: the window is dropped
      cnt_d   = '0;
      acc_d   = ACC_MIN;
      state_d = ST_RUN;
    end else begin
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
      if (mk_valid) begin
        acc_d = pooled;
        if (mk_last) begin
          wd_d   = pooled;
          wa_d   = BASE_A + cnt_q[ADDR_W-1:0];
          wena_d = 1'b0;
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (state_q == ST_RUN) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      acc_q   <= ACC_MIN;
      cnt_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      wena_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      wena_q  <= wena_d;
      done_q  <= done_d;
    end
  end

  assign wa_data = wa_q;
  assign wd_data = wd_q;
  assign wena    = wena_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pooling_result_writer.sv
// Directed bench for pooling_result_writer: one instance with default
// geometry (RD_LATENCY=1, BASE_ADDR=0) and one small full-run instance
// (2x3x2 windows, BASE_ADDR=100, RD_LATENCY=2).
module tb_pooling_result_writer;

  localparam int unsigned B_BATCH = 2;
  localparam int unsigned B_W     = 3;
  localparam int unsigned B_H     = 2;
  localparam int unsigned B_BASE  = 100;
  localparam int unsigned B_TOTAL = B_BATCH * B_W * B_H;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A signals
  logic go_a, cena_a, first_a, last_a;
  logic signed [7:0] samp_a, din_a;
  logic [11:0] wa_a;
  logic signed [7:0] wd_a;
  logic wena_a, done_a;

  // instance B signals
  logic go_b, cena_b, first_b, last_b;
  logic signed [7:0] samp_b, pipe_b, din_b;
  logic [11:0] wa_b;
  logic signed [7:0] wd_b;
  logic wena_b, done_b;

  // read-port model: data follows the address-aligned sample by RD_LATENCY
  initial begin
    din_a  = '0;
    pipe_b = '0;
    din_b  = '0;
  end
  always @(posedge clk) begin
    din_a  <= samp_a;
    pipe_b <= samp_b;
    din_b  <= pipe_b;
  end

  pooling_result_writer dut_a (
    .clk(clk), .rstn(rstn), .go(go_a), .cena(cena_a),
    .first_data(first_a), .last_data(last_a), .din(din_a),
    .wa_data(wa_a), .wd_data(wd_a), .wena(wena_a), .done(done_a)
  );

  pooling_result_writer #(
    .DATA_WIDTH(8), .OUTPUT_BATCH(B_BATCH), .OUT_WIDTH(B_W),
    .OUT_HEIGHT(B_H), .RD_LATENCY(2), .BASE_ADDR(B_BASE)
  ) dut_b (
    .clk(clk), .rstn(rstn), .go(go_b), .cena(cena_b),
    .first_data(first_b), .last_data(last_b), .din(din_b),
    .wa_data(wa_b), .wd_data(wd_b), .wena(wena_b), .done(done_b)
  );

  // write / done capture
  int wa_qa[$], wd_qa[$], wc_qa[$];
  int wa_qb[$], wd_qb[$], wc_qb[$];
  int done_na = 0, done_nb = 0, done_cb = 0;
  int lastc_a = 0, lastc_b = 0;

  always @(negedge clk) begin
    if (wena_a === 1'b0) begin
      wa_qa.push_back(int'(wa_a));
      wd_qa.push_back(int'(wd_a));
      wc_qa.push_back(cyc);
    end
    if (wena_b === 1'b0) begin
      wa_qb.push_back(int'(wa_b));
      wd_qb.push_back(int'(wd_b));
      wc_qb.push_back(cyc);
    end
    if (done_a === 1'b1) done_na++;
    if (done_b === 1'b1) begin
      done_nb++;
      done_cb = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input int v, input bit f, input bit l, input bit en);
    samp_a  = 8'(v);
    cena_a  = !en;
    first_a = f & en;
    last_a  = l & en;
    if (en && l) lastc_a = cyc;
    tick();
  endtask

  task automatic drv_b(input int v, input bit f, input bit l, input bit en);
    samp_b  = 8'(v);
    cena_b  = !en;
    first_b = f & en;
    last_b  = l & en;
    if (en && l) lastc_b = cyc;
    tick();
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drv_a(0, 0, 0, 0);
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) drv_b(0, 0, 0, 0);
  endtask

  task automatic pulse_go_a();
    go_a = 1'b1;
    drv_a(0, 0, 0, 0);
    go_a = 1'b0;
  endtask

  task automatic clear_a();
    wa_qa.delete();
    wd_qa.delete();
    wc_qa.delete();
  endtask

  task automatic check_win_a(input string tag, input int exp_wa, input int exp_wd);
    check({tag, "_count"}, wa_qa.size(), 1);
    if (wa_qa.size() > 0) begin
      check({tag, "_wa"}, wa_qa[0], exp_wa);
      check({tag, "_wd"}, wd_qa[0], exp_wd);
      check({tag, "_lat"}, wc_qa[0] - lastc_a, 2);
    end
    clear_a();
  endtask

  initial begin
    if (B_BASE + B_TOTAL > 4096) begin
      $display("FAIL addr_range: base+total=%0d limit 4096", B_BASE + B_TOTAL);
      $fatal(1);
    end
  end

  initial begin
    rstn = 1'b0;
    go_a = 1'b0; cena_a = 1'b0; first_a = 1'b0; last_a = 1'b0; samp_a = 8'sd7;
    go_b = 1'b0; cena_b = 1'b0; first_b = 1'b0; last_b = 1'b0; samp_b = 8'sd7;

    // reset held with reads active
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_wena", int'(wena_a), 1);
      check("rst_wa", int'(wa_a), 0);
      check("rst_wd", int'(wd_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_wena_b", int'(wena_b), 1);
    end
    rstn = 1'b1;
    cena_a = 1'b1;
    cena_b = 1'b1;
    idle_a(5);
    check("no_write_before_go", wa_qa.size(), 0);

    pulse_go_a();

    // 2x2 window, mixed signs
    drv_a(3, 1, 0, 1); drv_a(-5, 0, 0, 1); drv_a(7, 0, 0, 1); drv_a(1, 0, 1, 1);
    idle_a(4);
    check_win_a("win2x2", 0, 7);
    check("wena_idle", int'(wena_a), 1);
    check("wd_hold", int'(wd_a), 7);

    // all-negative window: signed compare
    drv_a(-8, 1, 0, 1); drv_a(-3, 0, 0, 1); drv_a(-100, 0, 0, 1); drv_a(-128, 0, 1, 1);
    idle_a(4);
    check_win_a("neg", 1, -3);

    // 1x1 window
    drv_a(-2, 1, 1, 1);
    idle_a(4);
    check_win_a("one", 2, -2);

    // gaps of 3 idle cycles inside a window
    drv_a(3, 1, 0, 1); idle_a(3);
    drv_a(-5, 0, 0, 1); idle_a(3);
    drv_a(7, 0, 0, 1); idle_a(3);
    drv_a(1, 0, 1, 1);
    idle_a(4);
    check_win_a("gaps", 3, 7);

    // go after 2 of 4 samples, then a fresh window
    drv_a(100, 1, 0, 1); drv_a(120, 0, 0, 1);
    pulse_go_a();
    drv_a(9, 1, 0, 1); drv_a(1, 0, 0, 1); drv_a(1, 0, 0, 1); drv_a(1, 0, 1, 1);
    idle_a(4);
    check_win_a("abort", 0, 9);

    // go coincident with the aligned last marker
    drv_a(50, 1, 0, 1); drv_a(60, 0, 1, 1);
    pulse_go_a();
    idle_a(3);
    check("go_prio_nowrite", wa_qa.size(), 0);
    clear_a();
    drv_a(5, 1, 1, 1);
    idle_a(4);
    check_win_a("after_prio", 0, 5);
    check("done_a_never", done_na, 0);

    // full run on instance B
    go_b = 1'b1;
    drv_b(0, 0, 0, 0);
    go_b = 1'b0;
    for (int k = 0; k < int'(B_TOTAL); k++) begin
      drv_b(k, 1, 0, 1);
      drv_b(-k, 0, 0, 1);
      drv_b(k + 1, 0, 0, 1);
      drv_b(k - 1, 0, 1, 1);
    end
    idle_b(6);
    check("full_count", wa_qb.size(), int'(B_TOTAL));
    for (int k = 0; k < int'(B_TOTAL); k++) begin
      if (k < wa_qb.size()) begin
        check($sformatf("full_wa%0d", k), wa_qb[k], int'(B_BASE) + k);
        check($sformatf("full_wd%0d", k), wd_qb[k], k + 1);
      end
    end
    if (wa_qb.size() == int'(B_TOTAL)) begin
      check("full_last_lat", wc_qb[B_TOTAL-1] - lastc_b, 3);
      check("done_timing", done_cb, wc_qb[B_TOTAL-1] + 1);
    end
    check("done_once", done_nb, 1);

    // after completion, no new go: addresses restart, no done
    wa_qb.delete(); wd_qb.delete(); wc_qb.delete();
    done_nb = 0;
    drv_b(33, 1, 1, 1);
    idle_b(5);
    check("post_count", wa_qb.size(), 1);
    if (wa_qb.size() > 0) begin
      check("post_wa", wa_qb[0], int'(B_BASE));
      check("post_wd", wd_qb[0], 33);
    end
    check("post_no_done", done_nb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pooling_result_writer.md
Name: pooling_result_writer

Overview:
- Consumer side of the pooling read-address stream. Accepts the read-side markers (cena/first_data/last_data) and the buffer read data, and reduces each window to its signed maximum.
- Emits one write (address, data, active-low enable) per window into the output feature buffer.
- Raises a one-cycle done pulse after the last window of the last batch is written.
- Sits between the input feature buffer read port and the output feature buffer write port, in parallel with the pooling iterator.

Parameters:
- DATA_WIDTH, 8, width of signed feature samples.
- OUTPUT_BATCH, 5, number of feature planes per run.
- OUT_WIDTH, 24, windows per output row.
- OUT_HEIGHT, 24, output rows per plane.
- RD_LATENCY, 1, cycles from read address/cena to valid din (1..4).
- BASE_ADDR, 0, first write address in the output buffer.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- go  in  1  start pulse; clears counters and pipeline.
- cena  in  1  active-low read enable from the iterator, address-aligned.
- first_data  in  1  first sample of a window, address-aligned.
- last_data  in  1  last sample of a window, address-aligned.
- din  in  DATA_WIDTH  signed read data, valid RD_LATENCY cycles after cena low.
- wa_data  out  12  output buffer write address.
- wd_data  out  DATA_WIDTH  pooled result.
- wena  out  1  active-low write enable.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset is synchronous on rstn low (one clock, fixed). Reset values: wa_data=0, wd_data=0, wena=1, done=0. Internal: acc = most-negative value, out_cnt=0, delay line all invalid.
- Alignment: cena, first_data and last_data pass through an RD_LATENCY-deep register chain, giving v_d (valid = ~cena delayed), f_d and l_d, aligned with din.
- Accumulator, on the cycle v_d=1:
  - f_d=1: acc <= din.
  - f_d=0: acc <= max(acc, din), signed compare.
- Write, same cycle v_d=1 and l_d=1:
  - next cycle: wd_data <= (f_d ? din : max(acc, din)), wa_data <= BASE_ADDR + out_cnt, wena <= 0.
  - out_cnt increments.
  - Latency from last din to write strobe: 1 cycle.
- wena is high every cycle with no write. wa_data and wd_data hold their last values while wena is high.
- f_d and l_d together (1x1 window): output = din.
- v_d=0: f_d and l_d are ignored, acc holds.
- Completion:
  - The write with out_cnt = TOTAL-1 (TOTAL = OUTPUT_BATCH*OUT_WIDTH*OUT_HEIGHT) sets done=1 on the cycle after wena=0.
  - out_cnt then wraps to 0.
  - done lasts exactly 1 cycle.
- go behaviour:
  - go=1 clears out_cnt, the delay line and acc on the next edge; any in-flight window is discarded and no write occurs for it.
  - go has priority over a coincident v_d/l_d.
  - go and rstn low together: reset wins.
- Valid samples arriving after completion without a new go are processed normally, with addresses restarting at BASE_ADDR.
- Width rules:
  - wa_data = (BASE_ADDR + out_cnt) mod 4096.
  - BASE_ADDR + TOTAL <= 4096 is required. The bench checks this constraint; the RTL does not saturate.
- State machine:
  - IDLE: go -> RUN.
  - RUN: final write -> DONE.
  - DONE: 1 cycle -> IDLE.
  - go in any state -> RUN with counters cleared.
  - State is not required for data processing; it gates done only.

Decomposition:
- Shared package entries:
  - DATA_WIDTH default.
  - Address width constant (12).
  - State enum {IDLE, RUN, DONE}.
  - Signed max function.
- One natural sub-module: pool_marker_delay (parameterised RD_LATENCY shift register for valid/first/last, with synchronous clear).

Test Plan:
- Reset: hold rstn=0 for 3 cycles while driving cena=0 and din=7 -> wena=1, wa_data=0, wd_data=0, done=0 throughout; no write after release until a go is given.
- 2x2 window, RD_LATENCY=1: samples 3,-5,7,1 with first on sample 1 and last on sample 4 -> exactly one write, wd_data=7, wa_data=0, wena low 1 cycle after din=1.
- All-negative window -8,-3,-100,-128 -> wd_data=-3 (signed compare, not unsigned). Window of 1x1 with din=-2 (first=last=1) -> wd_data=-2.
- Full run with OUTPUT_BATCH=2, OUT_WIDTH=3, OUT_HEIGHT=2, BASE_ADDR=100, RD_LATENCY=2 -> 12 writes at addresses 100..111 in order; done pulses once, 1 cycle after the write to 111.
- go asserted mid-window (after 2 of 4 samples) followed by a fresh window 9,1,1,1 -> only one write, wd_data=9, wa_data=BASE_ADDR; no write for the aborted window.
- Gaps: cena high for 3 cycles between samples of a window -> result unchanged versus the gapless case; wena never low during the gaps.
